// File: rtl/contador_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
// Purpose : Shared constants and types for the decade (MOD-10) up/down counter.
// Contents:
//   COUNT_WIDTH   - width of the count output (4 bits covers 0..9)
//   COUNT_MODULUS - number of count states (10, i.e. one BCD digit)
//   dir_t         - direction encoding, identical to the seletor input
//                   (DIR_DOWN = 0, DIR_UP = 1)
// -----------------------------------------------------------------------------
package contador_pkg;

    localparam int COUNT_WIDTH   = 4;
    localparam int COUNT_MODULUS = 10;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

endpackage : contador_pkg

// File: rtl/contador_up_down.sv
// -----------------------------------------------------------------------------
// contador_up_down
// Purpose : Synchronous MOD-MODULUS up/down counter (default: one BCD digit).
//           Steps on every rising clk edge while out of reset; direction is
//           chosen per edge by seletor. Wraps 9->0 going up and 0->9 going
//           down. Any value outside 0..MODULUS-1 is forced to 0 on the next
//           edge, so the counter recovers by itself from a corrupted state.
// Ports   :
//   clk      in   1      system clock, rising-edge active
//   reset    in   1      asynchronous, active-low; 0 clears contador at once
//   seletor  in   1      direction: 1 = up, 0 = down (sampled at clk rise)
//   contador out  WIDTH  registered count value, 0..MODULUS-1
// -----------------------------------------------------------------------------
module contador_up_down
    import contador_pkg::*;
#(
    parameter int MODULUS = COUNT_MODULUS,
    parameter int WIDTH   = COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seletor,
    output logic [WIDTH-1:0] contador
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;

    // Next-state rule. Wrap points are detected by explicit comparison so
    // that the behaviour does not depend on binary overflow of WIDTH bits.
    function automatic logic [WIDTH-1:0] next_count(
        input logic [WIDTH-1:0] cur,
        input dir_t             dir
    );
        logic [WIDTH-1:0] nxt;
        if (cur > MAX_COUNT) begin
            // Unreachable in normal operation; recover to 0 in either direction.
            nxt = '0;
        end else if (dir == DIR_UP) begin
            nxt = (cur == MAX_COUNT) ? '0 : cur + ONE;
        end else begin
            nxt = (cur == '0) ? MAX_COUNT : cur - ONE;
        end
        return nxt;
    endfunction

    always_comb begin
        w_count_next = next_count(r_count, dir_t'(seletor));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // The output is the register itself: no combinational input-to-output path.
    assign contador = r_count;

`ifndef SYNTHESIS
    // The count must never leave the legal range while out of reset.
    a_count_in_range : assert property (
        @(posedge clk) disable iff (!reset) (contador <= MAX_COUNT)
    );
`endif

endmodule : contador_up_down

// File: tb/tb_contador_up_down.sv
// -----------------------------------------------------------------------------
// tb_contador_up_down
// Purpose : Self-checking bench for contador_up_down (MODULUS = 10).
//           Directed steps (reset hold, up/down wrap, direction changes,
//           asynchronous reset mid-count) followed by a randomized soak with
//           random direction and occasional reset pulses. Expected values come
//           from a plain modulo-10 arithmetic model kept in the bench.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_contador_up_down;

    localparam int MOD = 10;

    logic       clk;
    logic       reset;
    logic       seletor;
    logic [3:0] contador;

    int checks;
    int errors;
    int model;      // expected count value

    contador_up_down #(
        .MODULUS (10),
        .WIDTH   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .seletor  (seletor),
        .contador (contador)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int expected);
        checks++;
        assert (contador === 4'(expected))
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, contador, expected);
        end
    endtask

    // One clock step: drive direction, wait for the edge, sample 1 ns later,
    // advance the reference model and compare.
    task automatic step(input logic dir, input string tag);
        seletor = dir;
        @(posedge clk);
        #1;
        if (dir) model = (model + 1) % MOD;
        else     model = (model + MOD - 1) % MOD;
        check(tag, model);
    endtask

    // Asynchronous reset pulse issued away from the clock edge; the count must
    // read 0 before any further edge occurs.
    task automatic reset_pulse(input int width_ns, input string tag);
        reset = 1'b0;
        #1;
        model = 0;
        check(tag, 0);
        #(width_ns - 1);
        reset = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        model   = 0;
        reset   = 1'b0;
        seletor = 1'b0;

        // Reset held for 5 clocks with seletor toggling: count stays 0.
        for (int i = 0; i < 5; i++) begin
            seletor = i[0];
            @(posedge clk);
            #1;
            check("reset_hold", 0);
        end

        // Release and count up 12 clocks: 1..9,0,1,2.
        reset = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1, "up_wrap");
        check("up_wrap_end", 2);

        // Back to 0, then count down 12 clocks: 9,8,..,1,0,9,8.
        reset_pulse(3, "reset_before_down");
        for (int i = 0; i < 12; i++) step(1'b0, "down_wrap");
        check("down_wrap_end", 8);

        // Up to 4, down 3 (3,2,1), up 2 (2,3).
        reset_pulse(3, "reset_before_dir");
        for (int i = 0; i < 4; i++) step(1'b1, "dir_up4");
        for (int i = 0; i < 3; i++) step(1'b0, "dir_down3");
        for (int i = 0; i < 2; i++) step(1'b1, "dir_up2");
        check("dir_end", 3);

        // Single-cycle opposite pulses: each gives exactly one opposite step.
        step(1'b1, "pulse_up");
        step(1'b0, "pulse_down");
        step(1'b1, "pulse_up");
        step(1'b1, "pulse_up");
        step(1'b0, "pulse_down");

        // Reset asserted mid-cycle at count 6: 0 before the next edge.
        reset_pulse(3, "reset_before_mid");
        for (int i = 0; i < 6; i++) step(1'b1, "to_six");
        #2;
        reset_pulse(3, "reset_mid_at6");

        // Counting up at 7, reset low for 3 ns, release with seletor=1: 0,1,2,3.
        @(posedge clk);
        #1;
        model = 1;                     // first edge after the release above
        check("after_mid_release", model);
        for (int i = 0; i < 6; i++) step(1'b1, "to_seven");
        check("at_seven", 7);
        reset_pulse(3, "reset_at7");
        for (int i = 0; i < 3; i++) step(1'b1, "resume_up");
        check("resume_end", 3);

        // Random soak: random direction, occasional reset pulses.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset_pulse(int'($urandom_range(2, 4)), "soak_reset");
            end
            step(1'($urandom_range(0, 1)), "soak");
            checks++;
            assert (contador <= 4'd9)
            else begin
                errors++;
                $error("FAIL soak_range: observed %0d expected <= 9", contador);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_contador_up_down
